rat_path_checker: RTL
=====================

# rat_path_checker

Replays and validates the `Move` stream produced by the maze-solving rat while it runs in `Run` mode. The block tracks the rat's position on the same 2^N x 2^N maze map and reads each target cell before committing a step. It flags the first illegal step: out-of-bounds, wall hit, step overflow, or a stream that ends away from the goal. It sits between the solver's output and the map memory's second read port, and serves as the self-check and consumer end of the solver's move interface.

## Interface
- `N`, 4: log2 of maze side; the map is 2^N x 2^N, and map address is `{i,j}`, 2N bits.
- `SW`, 8: step-counter width; the maximum legal path length is 2^SW-1.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle pulse; clears state and begins a check from (0,0).
- `MoveValid` in 1: a move is offered on `Move` this cycle.
- `Move` in 2: 00 up (i-1), 01 right (j+1), 10 left (j-1), 11 down (i+1).
- `StreamEnd` in 1: the source signals it has no more moves (solver Done/Fail).
- `MoveReady` out 1: the checker can accept a move this cycle.
- `mapAdr` out 2N: map read address `{ni,nj}`.
- `mapData` in 1: combinational map read; 1 = wall, 0 = free.
- `Busy` out 1: a check is in progress.
- `Pass` out 1: the path reached the goal (2^N-1, 2^N-1); sticky until `Start` or reset.
- `Fail` out 1: the path is illegal; sticky until `Start` or reset.
- `FailCode` out 2: 00 bounds, 01 wall, 10 overflow, 11 short (ended before goal).
- `PosI`, `PosJ` out N each: current committed position.
- `Steps` out SW: number of committed moves.

## Operation
- FSM states: IDLE, TRACK, LOOKUP, PASS, FAIL.
- **Reset (RST=0):** the state goes to IDLE. All outputs are 0, `mapAdr`=0, and the position is (0,0).
- **IDLE:** `Start` clears the position, `Steps`, and flags, then enters TRACK.
- **TRACK:** `MoveReady`=1. A move is accepted on `MoveValid` && `MoveReady`.
  - The candidate `ni`,`nj` is computed with N+1-bit signed arithmetic.
  - If the candidate is out of range [0, 2^N-1], the FSM goes to FAIL with code 00 and does not read the map.
  - If `Steps` == 2^SW-1, it goes to FAIL with code 10.
  - Otherwise it latches the candidate and enters LOOKUP.
- **TRACK, `StreamEnd` with no valid move:**
  - At the goal → PASS. (The goal can only be reached by a commit, so this is a re-check.)
  - Otherwise → FAIL with code 11.
- **TRACK, `MoveValid` and `StreamEnd` in the same cycle:** the move is processed first and the end is ignored. The source must hold `StreamEnd` until `MoveReady` is seen again.
- **LOOKUP:**
  - `mapAdr` = latched candidate and `MoveReady`=0. `mapData` is sampled at the end of the cycle.
  - If `mapData`=1 → FAIL with code 01; the position is unchanged.
  - Otherwise the position is committed and `Steps`+1.
  - If the new position is the goal → PASS; else → TRACK.
- **PASS/FAIL:** terminal states. `Busy`=0 and `MoveValid` is ignored. `Start` restarts a check.
- **`Start` in any state:** synchronous restart, which overrides any in-flight LOOKUP.
- **Cell (0,0):** assumed free and never read.

## Timing
- Throughput is one move per 2 cycles: accepted in TRACK, resolved in LOOKUP.
- `Pass`/`Fail` rise on the clock edge that ends the deciding cycle:
  - 1 cycle after acceptance for bounds or overflow.
  - 2 cycles after acceptance for wall or goal.
  - 1 cycle after `StreamEnd` for short.
- `Busy` is high in TRACK and LOOKUP, and is a registered output.
- `mapAdr` is registered and holds its last value outside LOOKUP.
- `Pass` and `Fail` are never high together.

## Structure
- Shared package `rat_pkg`:
  - Move encoding constants: `MV_UP`, `MV_RIGHT`, `MV_LEFT`, `MV_DOWN`.
  - FailCode constants.
  - The FSM state typedef, also reused by the solver controller.
- Single module; no sub-module is needed. A next-position helper function lives in `rat_pkg` so that the solver and the checker share the move arithmetic.

## Test plan
- **Short legal path.** Open map with N=2 (4x4). `Start`, then moves 01,01,01,11,11,11. Required: `Pass`=1, `Steps`=6, position (3,3), `Pass` rising 2 cycles after the 6th acceptance.
- **Bounds.** `Start`, then move 00 from (0,0). Required: `Fail`=1 and `FailCode`=00 one cycle later, `Steps`=0, `mapAdr` never driven to a new cell.
- **Wall.** Wall at (0,1). `Start`, then move 01. Required: `mapAdr`=0x01 in LOOKUP, `Fail`=1, `FailCode`=01, position stays (0,0).
- **Short path.** `Start`, moves 11,11, then `StreamEnd`. Required: `Fail`=1, `FailCode`=11, `Steps`=2.
- **Overflow.** SW=3 on an open map. Oscillate 01/10 for 7 moves, then offer an 8th. Required: `Fail`=1 with `FailCode`=10, `Steps`=7.
- **Async reset and restart.** Assert RST low mid-LOOKUP. Required: all outputs 0 immediately. Then `Start` in the FAIL state: required `Fail`=0, `Busy`=1, `Steps`=0 on the next cycle.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared definitions for the maze rat: move and fail encodings, FSM states,
// and the next-position arithmetic used by both the solver and the checker.
package rat_pkg;

  localparam int CW = 16;

  typedef logic signed [CW-1:0] coord_t;

  typedef struct packed {
    coord_t i;
    coord_t j;
  } pos_t;

  localparam logic [1:0] MV_UP    = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_DOWN  = 2'b11;

  localparam logic [1:0] FC_BOUNDS   = 2'b00;
  localparam logic [1:0] FC_WALL     = 2'b01;
  localparam logic [1:0] FC_OVERFLOW = 2'b10;
  localparam logic [1:0] FC_SHORT    = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    LOOKUP = 3'd2,
    PASS   = 3'd3,
    FAIL   = 3'd4
  } rat_state_t;

  // Signed and wider than any maze coordinate, so stepping off either edge is visible.
  function automatic pos_t next_pos(input pos_t p, input logic [1:0] mv);
    pos_t n;
    n = p;
    case (mv)
      MV_UP:    n.i = p.i - coord_t'(1);
      MV_RIGHT: n.j = p.j + coord_t'(1);
      MV_LEFT:  n.j = p.j - coord_t'(1);
      MV_DOWN:  n.i = p.i + coord_t'(1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rat_path_checker.sv
// Replays the solver's move stream over the maze map and flags the first illegal step.
// One move per two cycles (accept in TRACK, map lookup in LOOKUP); MoveReady is low during LOOKUP.
module rat_path_checker
  import rat_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            MoveValid,
  input  logic [1:0]      Move,
  input  logic            StreamEnd,
  output logic            MoveReady,
  output logic [2*N-1:0]  mapAdr,
  input  logic            mapData,
  output logic            Busy,
  output logic            Pass,
  output logic            Fail,
  output logic [1:0]      FailCode,
  output logic [N-1:0]    PosI,
  output logic [N-1:0]    PosJ,
  output logic [SW-1:0]   Steps
);

  localparam coord_t MAXC = coord_t'((2 ** N) - 1);

  rat_state_t state, state_nxt;
  logic [1:0] code_nxt;
  pos_t       cur, cand;
  logic       oob, at_max, at_goal, adr_goal, take_move;

  assign cur.i    = {{(CW-N){1'b0}}, PosI};
  assign cur.j    = {{(CW-N){1'b0}}, PosJ};
  assign cand     = next_pos(cur, Move);
  assign oob      = cand.i[CW-1] || (cand.i > MAXC) || cand.j[CW-1] || (cand.j > MAXC);
  assign at_max   = &Steps;
  assign at_goal  = &{PosI, PosJ};
  assign adr_goal = &mapAdr;
  assign take_move = (state == TRACK) && MoveValid && !oob && !at_max;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = FailCode;
    if (Start) begin
      state_nxt = TRACK;
    end else begin
      case (state)
        TRACK: begin
          // A valid move wins over a simultaneous StreamEnd; the source keeps End asserted.
          if (MoveValid) begin
            if (oob) begin
              state_nxt = FAIL;
              code_nxt  = FC_BOUNDS;
            end else if (at_max) begin
              state_nxt = FAIL;
              code_nxt  = FC_OVERFLOW;
            end else begin
              state_nxt = LOOKUP;
            end
          end else if (StreamEnd) begin
            if (at_goal) begin
              state_nxt = PASS;
            end else begin
              state_nxt = FAIL;
              code_nxt  = FC_SHORT;
            end
          end
        end
        LOOKUP: begin
          if (mapData) begin
            state_nxt = FAIL;
            code_nxt  = FC_WALL;
          end else if (adr_goal) begin
            state_nxt = PASS;
          end else begin
            state_nxt = TRACK;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    MoveReady = (state == TRACK);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mapAdr   <= '0;
      PosI     <= '0;
      PosJ     <= '0;
      Steps    <= '0;
      FailCode <= '0;
      Busy     <= 1'b0;
      Pass     <= 1'b0;
      Fail     <= 1'b0;
    end else begin
      Busy <= (state_nxt == TRACK) || (state_nxt == LOOKUP);
      Pass <= (state_nxt == PASS);
      Fail <= (state_nxt == FAIL);
      if (Start) begin
        PosI     <= '0;
        PosJ     <= '0;
        Steps    <= '0;
        FailCode <= '0;
      end else begin
        // The address register doubles as the latched candidate cell.
        if (take_move) mapAdr <= {cand.i[N-1:0], cand.j[N-1:0]};
        if ((state == LOOKUP) && !mapData) begin
          PosI  <= mapAdr[2*N-1:N];
          PosJ  <= mapAdr[N-1:0];
          Steps <= Steps + SW'(1);
        end
        if ((state_nxt == FAIL) && (state != FAIL)) FailCode <= code_nxt;
      end
    end
  end

endmodule
